// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the pipeline stall/flush controller.
//   hz_state_e          : 2-bit controller state, visible on o_hazard_state
//   hz_ctrl_t           : bundle of the per-stage stall/flush controls
//   DefaultRegAddrWidth : register address width of the RV32I core
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int unsigned DefaultRegAddrWidth = 5;

   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_REDIRECT   = 2'd2,
      HZ_MEM_WAIT   = 2'd3
   } hz_state_e;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_stall;
      logic id_ex_flush;
      logic ex_mem_stall;
      logic mem_wb_bubble;
   } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Pure combinational load-use comparator: flags when the load in EX writes a
// register that the instruction in ID actually reads. x0 never creates a
// hazard because it is hard-wired to zero.
// Ports:
//   i_id_src1/i_id_src2          : rs1/rs2 of the ID instruction
//   i_id_uses_src1/i_id_uses_src2: the ID instruction reads rs1/rs2
//   i_ex_mem_read                : EX instruction is a load
//   i_ex_rd                      : EX destination register
//   o_load_use                   : load-use hazard present
// -----------------------------------------------------------------------------
module hazard_detect
   import hazard_pkg::*;
#(
   parameter int unsigned RegAddrWidth = DefaultRegAddrWidth
) (
   input  logic [RegAddrWidth-1:0] i_id_src1,
   input  logic [RegAddrWidth-1:0] i_id_src2,
   input  logic                    i_id_uses_src1,
   input  logic                    i_id_uses_src2,
   input  logic                    i_ex_mem_read,
   input  logic [RegAddrWidth-1:0] i_ex_rd,
   output logic                    o_load_use
);

   logic w_src1_hit;
   logic w_src2_hit;
   logic w_rd_nonzero;

   assign w_src1_hit   = i_id_uses_src1 & (i_id_src1 == i_ex_rd);
   assign w_src2_hit   = i_id_uses_src2 & (i_id_src2 == i_ex_rd);
   assign w_rd_nonzero = (i_ex_rd != '0);
   assign o_load_use   = i_ex_mem_read & w_rd_nonzero & (w_src1_hit | w_src2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Priority: memory wait > EX redirect > load-use.
//
// Data-memory handshake: the MEM stage holds i_mem_req high for the whole
// access; the access completes in the cycle where i_mem_ready is also high.
// A cycle with i_mem_req = 1 and i_mem_ready = 0 is a wait cycle, during which
// the whole front of the pipeline freezes and MEM/WB receives a bubble.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   i_id_src1/2         : ID source registers, i_id_uses_src1/2 qualifiers
//   i_ex_mem_read/i_ex_rd : EX load flag and destination
//   i_ex_redirect       : taken branch/jump resolved in EX
//   i_mem_req/i_mem_ready : data-memory handshake (see above)
//   o_pc_stall .. o_mem_wb_bubble : per-stage stall/flush controls
//   o_hazard_state      : current controller state (hz_state_e encoding)
//   o_mem_timeout       : sticky memory-timeout error
//   o_stall_cycles      : saturating count of cycles with o_pc_stall = 1
// All outputs read 0 while reset is high.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned RegAddrWidth = DefaultRegAddrWidth,
   parameter int unsigned MemTimeout   = 64,
   parameter int unsigned CntWidth     = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [RegAddrWidth-1:0] i_id_src1,
   input  logic [RegAddrWidth-1:0] i_id_src2,
   input  logic                    i_id_uses_src1,
   input  logic                    i_id_uses_src2,
   input  logic                    i_ex_mem_read,
   input  logic [RegAddrWidth-1:0] i_ex_rd,
   input  logic                    i_ex_redirect,
   input  logic                    i_mem_req,
   input  logic                    i_mem_ready,
   output logic                    o_pc_stall,
   output logic                    o_if_id_stall,
   output logic                    o_if_id_flush,
   output logic                    o_id_ex_stall,
   output logic                    o_id_ex_flush,
   output logic                    o_ex_mem_stall,
   output logic                    o_mem_wb_bubble,
   output logic [1:0]              o_hazard_state,
   output logic                    o_mem_timeout,
   output logic [CntWidth-1:0]     o_stall_cycles
);

   // Timeout counter only needs to reach MemTimeout-1 (MemTimeout >= 2).
   localparam int unsigned         ToWidth = $clog2(MemTimeout);
   localparam logic [ToWidth-1:0]  ToLast  = ToWidth'(MemTimeout - 1);

   hz_state_e             r_state;
   hz_state_e             w_next_state;
   hz_ctrl_t              w_ctrl;
   logic                  w_load_use;
   logic                  w_mem_wait;
   logic [ToWidth-1:0]    r_to_cnt;
   logic                  r_timeout;
   logic [CntWidth-1:0]   r_stall_cycles;

   hazard_detect #(
      .RegAddrWidth(RegAddrWidth)
   ) u_detect (
      .i_id_src1      (i_id_src1),
      .i_id_src2      (i_id_src2),
      .i_id_uses_src1 (i_id_uses_src1),
      .i_id_uses_src2 (i_id_uses_src2),
      .i_ex_mem_read  (i_ex_mem_read),
      .i_ex_rd        (i_ex_rd),
      .o_load_use     (w_load_use)
   );

   assign w_mem_wait = i_mem_req & ~i_mem_ready;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= HZ_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and controls; every control is zero while reset is high.
   always_comb begin
      w_ctrl       = '0;
      w_next_state = HZ_RUN;
      if (!reset) begin
         if (w_mem_wait) begin
            w_ctrl.pc_stall      = 1'b1;
            w_ctrl.if_id_stall   = 1'b1;
            w_ctrl.id_ex_stall   = 1'b1;
            w_ctrl.ex_mem_stall  = 1'b1;
            w_ctrl.mem_wb_bubble = 1'b1;
            w_next_state         = HZ_MEM_WAIT;
         end else if (i_ex_redirect) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
            w_next_state       = HZ_REDIRECT;
         end else if (w_load_use && (r_state != HZ_REDIRECT)) begin
            // In REDIRECT the ID slot holds a flushed bubble, so its
            // register fields are meaningless and must not stall.
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.if_id_stall = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
            w_next_state       = HZ_LOAD_STALL;
         end
      end
   end

   // Memory-wait timeout: counts consecutive wait cycles, then latches the
   // error; the counter saturates and the freeze itself continues.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (w_mem_wait) begin
         if (r_to_cnt == ToLast) begin
            r_timeout <= 1'b1;
         end else begin
            r_to_cnt <= r_to_cnt + ToWidth'(1);
         end
      end else begin
         r_to_cnt <= '0;
      end
   end

   // Performance counter: saturates at all-ones, never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cycles <= '0;
      end else if (w_ctrl.pc_stall && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + CntWidth'(1);
      end
   end

   assign o_pc_stall      = w_ctrl.pc_stall;
   assign o_if_id_stall   = w_ctrl.if_id_stall;
   assign o_if_id_flush   = w_ctrl.if_id_flush;
   assign o_id_ex_stall   = w_ctrl.id_ex_stall;
   assign o_id_ex_flush   = w_ctrl.id_ex_flush;
   assign o_ex_mem_stall  = w_ctrl.ex_mem_stall;
   assign o_mem_wb_bubble = w_ctrl.mem_wb_bubble;
   assign o_hazard_state  = reset ? 2'b00 : r_state;
   assign o_mem_timeout   = r_timeout & ~reset;
   assign o_stall_cycles  = reset ? '0 : r_stall_cycles;

   // The instruction released by a load-use stall already has its operand
   // forwardable, so a second load-use right after a stall means the
   // pipeline feeding this block is broken.
   a_no_repeat_load_use : assert property (
      @(posedge clock) disable iff (reset)
      ((r_state == HZ_LOAD_STALL) && !w_mem_wait && !i_ex_redirect) |-> !w_load_use
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios with literal expectations, then randomized traffic. A
// behavioural model tracks the controller and a negedge process compares every
// DUT output against it each cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int RAW = 5;
   localparam int MT  = 4;
   localparam int CW  = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [RAW-1:0] id_src1, id_src2, ex_rd;
   logic           id_uses_src1, id_uses_src2, ex_mem_read, ex_redirect;
   logic           mem_req, mem_ready;
   logic           pc_stall, if_id_stall, if_id_flush, id_ex_stall;
   logic           id_ex_flush, ex_mem_stall, mem_wb_bubble, mem_timeout;
   logic [1:0]     hazard_state;
   logic [CW-1:0]  stall_cycles;
   logic [6:0]     dut_ctrl;

   assign dut_ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                      id_ex_flush, ex_mem_stall, mem_wb_bubble};

   pipeline_hazard_ctrl #(
      .RegAddrWidth(RAW),
      .MemTimeout  (MT),
      .CntWidth    (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .i_id_src1      (id_src1),
      .i_id_src2      (id_src2),
      .i_id_uses_src1 (id_uses_src1),
      .i_id_uses_src2 (id_uses_src2),
      .i_ex_mem_read  (ex_mem_read),
      .i_ex_rd        (ex_rd),
      .i_ex_redirect  (ex_redirect),
      .i_mem_req      (mem_req),
      .i_mem_ready    (mem_ready),
      .o_pc_stall     (pc_stall),
      .o_if_id_stall  (if_id_stall),
      .o_if_id_flush  (if_id_flush),
      .o_id_ex_stall  (id_ex_stall),
      .o_id_ex_flush  (id_ex_flush),
      .o_ex_mem_stall (ex_mem_stall),
      .o_mem_wb_bubble(mem_wb_bubble),
      .o_hazard_state (hazard_state),
      .o_mem_timeout  (mem_timeout),
      .o_stall_cycles (stall_cycles)
   );

   // ---------------- scoreboard ----------------
   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic cmp(input string name, input int act, input int exp);
      n_compared++;
      if (act != exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
   //                        id_ex_flush, ex_mem_stall, mem_wb_bubble}
   localparam logic [6:0] FREEZE = 7'b1101011;
   localparam logic [6:0] FLUSH  = 7'b0010100;
   localparam logic [6:0] LSTALL = 7'b1100100;

   int m_state   = 0;   // 0 RUN, 1 LOAD_STALL, 2 REDIRECT, 3 MEM_WAIT
   int m_wait    = 0;   // consecutive wait cycles seen so far
   int m_stalls  = 0;
   bit m_timeout = 1'b0;

   function automatic bit model_load_use();
      if (!ex_mem_read || ex_rd == 0) return 1'b0;
      return (id_uses_src1 && id_src1 == ex_rd) || (id_uses_src2 && id_src2 == ex_rd);
   endfunction

   function automatic logic [6:0] model_ctrl();
      if (reset) return 7'b0;
      if (mem_req && !mem_ready) return FREEZE;
      if (ex_redirect) return FLUSH;
      if (model_load_use() && m_state != 2) return LSTALL;
      return 7'b0;
   endfunction

   always @(posedge clock) begin
      logic [6:0] c;
      if (reset) begin
         m_state = 0; m_wait = 0; m_stalls = 0; m_timeout = 1'b0;
      end else begin
         c = model_ctrl();
         if (c[6] && m_stalls < CNT_MAX) m_stalls++;
         if (mem_req && !mem_ready) begin
            m_wait++;
            if (m_wait >= MT) m_timeout = 1'b1;
         end else begin
            m_wait = 0;
         end
         if (c == FREEZE)      m_state = 3;
         else if (c == FLUSH)  m_state = 2;
         else if (c == LSTALL) m_state = 1;
         else                  m_state = 0;
      end
   end

   // Single compare process: every cycle, away from the active edge.
   always @(negedge clock) begin
      cmp("ctrl",  dut_ctrl,     model_ctrl());
      cmp("state", hazard_state, reset ? 0 : m_state);
      cmp("tmo",   mem_timeout,  reset ? 0 : m_timeout);
      cmp("cnt",   stall_cycles, reset ? 0 : m_stalls);
   end

   // ---------------- driver tasks ----------------
   task automatic idle_in();
      id_src1 = '0; id_src2 = '0; ex_rd = '0;
      id_uses_src1 = 0; id_uses_src2 = 0; ex_mem_read = 0;
      ex_redirect = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic rand_in();
      reset        = ($urandom_range(0, 99) == 0);
      id_src1      = RAW'($urandom_range(0, 3));
      id_src2      = RAW'($urandom_range(0, 3));
      ex_rd        = RAW'($urandom_range(0, 3));
      id_uses_src1 = ($urandom_range(0, 9) < 7);
      id_uses_src2 = ($urandom_range(0, 9) < 7);
      ex_mem_read  = ($urandom_range(0, 9) < 4);
      ex_redirect  = ($urandom_range(0, 99) < 15);
      mem_req      = ($urandom_range(0, 9) < 3);
      mem_ready    = ($urandom_range(0, 1) == 1);
      // A correct pipeline never repeats a load-use right after a stall.
      if (m_state == 1) ex_mem_read = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_in();
      reset = 1;
      @(negedge clock);
      cmp("dir_rst_ctrl", dut_ctrl, 0);
      cmp("dir_rst_state", hazard_state, 0);
      step(); step();
      reset = 0;

      // Load to x5, ID reads rs1 = x5: one stall cycle
      ex_mem_read = 1; ex_rd = 5; id_src1 = 5; id_uses_src1 = 1;
      @(negedge clock);
      cmp("dir_lu_ctrl", dut_ctrl, 7'b1100100);
      cmp("dir_lu_state0", hazard_state, 0);
      step();
      idle_in();
      @(negedge clock);
      cmp("dir_lu_state1", hazard_state, 1);
      cmp("dir_lu_release", dut_ctrl, 0);
      step();
      @(negedge clock);
      cmp("dir_lu_state_back", hazard_state, 0);
      cmp("dir_lu_count", stall_cycles, 1);
      step();

      // x0 destination and unused sources never stall
      ex_mem_read = 1; ex_rd = 0; id_src1 = 0; id_uses_src1 = 1;
      @(negedge clock);
      cmp("dir_x0", dut_ctrl, 0);
      step();
      ex_rd = 5; id_src1 = 5; id_src2 = 5; id_uses_src1 = 0; id_uses_src2 = 0;
      @(negedge clock);
      cmp("dir_unused_src", dut_ctrl, 0);
      step();

      // Redirect, then load-use in the REDIRECT cycle is suppressed
      idle_in(); ex_redirect = 1;
      @(negedge clock);
      cmp("dir_redir_flush", dut_ctrl, 7'b0010100);
      step();
      idle_in(); ex_mem_read = 1; ex_rd = 7; id_src2 = 7; id_uses_src2 = 1;
      @(negedge clock);
      cmp("dir_redir_state", hazard_state, 2);
      cmp("dir_redir_suppress", dut_ctrl, 0);
      step();
      idle_in();
      @(negedge clock);
      cmp("dir_redir_back", hazard_state, 0);
      step();

      // Three wait cycles with redirect held, then the flush on ready
      mem_req = 1; mem_ready = 0; ex_redirect = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         cmp("dir_freeze", dut_ctrl, 7'b1101011);
         step();
      end
      mem_ready = 1;
      @(negedge clock);
      cmp("dir_release_flush", dut_ctrl, 7'b0010100);
      cmp("dir_wait_state", hazard_state, 3);
      step();
      idle_in();
      @(negedge clock);
      cmp("dir_freeze_count", stall_cycles, 4);
      cmp("dir_after_wait_state", hazard_state, 2);
      cmp("dir_short_wait_tmo", mem_timeout, 0);
      step();

      // Six wait cycles with MemTimeout = 4: error visible from cycle 5
      mem_req = 1; mem_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clock);
         if (i == 4) cmp("dir_tmo_not_yet", mem_timeout, 0);
         if (i == 5) cmp("dir_tmo_set", mem_timeout, 1);
         step();
      end
      mem_ready = 1;
      @(negedge clock);
      cmp("dir_tmo_ready", mem_timeout, 1);
      cmp("dir_tmo_ready_ctrl", dut_ctrl, 0);
      step();
      idle_in();
      @(negedge clock);
      cmp("dir_tmo_sticky", mem_timeout, 1);
      cmp("dir_tmo_count", stall_cycles, 10);
      step();

      // Reset mid-wait: everything reads 0
      reset = 1; mem_req = 1; mem_ready = 0; ex_redirect = 1;
      @(negedge clock);
      cmp("dir_rst_mid_ctrl", dut_ctrl, 0);
      cmp("dir_rst_mid_tmo", mem_timeout, 0);
      cmp("dir_rst_mid_state", hazard_state, 0);
      step();
      reset = 0; idle_in();
      @(negedge clock);
      cmp("dir_rst_clr_tmo", mem_timeout, 0);
      cmp("dir_rst_clr_cnt", stall_cycles, 0);
      step();

      // Saturation of stall_cycles at all-ones
      mem_req = 1; mem_ready = 0;
      repeat (CNT_MAX + 2) step();
      @(negedge clock);
      cmp("dir_sat", stall_cycles, CNT_MAX);
      step();
      @(negedge clock);
      cmp("dir_sat_hold", stall_cycles, CNT_MAX);
      reset = 1;
      step();
      reset = 0; idle_in();
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rand_in();
         step();
      end
      reset = 0; idle_in();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
